src_control_sequencer: RTL and testbench

- Hardwired Moore control sequencer for the Mini-SRC 32-bit CPU.
- Decodes IR[31:27], steps through fetch/execute T-states, and drives the datapath and memory strobes.
- Includes the CON FF branch-condition register.
- Sits between the IR/bus of the datapath, the select-encode logic and the synchronous RAM (1-cycle read latency).

---
 rtl/src_pkg.sv | 109 ++++++++++
 rtl/src_control_sequencer_if.sv | 30 +++
 rtl/src_control_sequencer_con_ff.sv | 32 +++
 rtl/src_control_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_src_control_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/src_pkg.sv
// Shared definitions for the Mini-SRC hardwired control sequencer:
// opcodes, ALU codes, FSM states, branch condition codes and the control word.
package src_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SHR = 4'd2;
    localparam logic [3:0] ALU_SHL = 4'd3;
    localparam logic [3:0] ALU_ROR = 4'd4;
    localparam logic [3:0] ALU_ROL = 4'd5;
    localparam logic [3:0] ALU_AND = 4'd6;
    localparam logic [3:0] ALU_OR  = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    localparam logic [1:0] CC_ZERO = 2'b00;
    localparam logic [1:0] CC_NZ   = 2'b01;
    localparam logic [1:0] CC_POS  = 2'b10;
    localparam logic [1:0] CC_NEG  = 2'b11;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
        S_T6, S_T7, S_T8, S_T9, S_DIV, S_HALT
    } state_t;

    typedef struct packed {
        logic       run;
        logic       clear;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       ba_read;
        logic       regfile_read;
        logic       regfile_write;
        logic       hi_write;
        logic       lo_write;
        logic       z_write;
        logic       pc_write;
        logic       mdr_write;
        logic       ir_write;
        logic       y_write;
        logic       mar_write;
        logic       mem_read;
        logic       mem_write;
        logic       outport_write;
        logic       conff_write;
        logic       hi_read;
        logic       lo_read;
        logic       z_lo_read;
        logic       z_hi_read;
        logic       pc_read;
        logic       mdr_read;
        logic       inport_read;
        logic       c_read;
        logic       div_reset;
        logic       mdr_select;
        logic       inc_pc;
        logic [3:0] alu_opcode;
    } ctrl_t;

    // ALU operation implied by an arithmetic/logic opcode (immediates map to their base op).
    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/src_control_sequencer_if.sv
// Datapath-facing signal bundle of the control sequencer; master = sequencer, slave = datapath/RAM.
interface src_control_sequencer_if;
    logic        stop;
    logic [31:0] ir;
    logic [31:0] bus;
    logic        run, clear, gra, grb, grc, ba_read, regfile_read, regfile_write;
    logic        hi_write, lo_write, z_write, pc_write, mdr_write, ir_write, y_write, mar_write;
    logic        mem_read, mem_write, outport_write, conff_write;
    logic        hi_read, lo_read, z_lo_read, z_hi_read, pc_read, mdr_read, inport_read, c_read;
    logic [3:0]  alu_opcode;
    logic        div_reset, mdr_select, inc_pc;

    modport master (
        input  stop, ir, bus,
        output run, clear, gra, grb, grc, ba_read, regfile_read, regfile_write,
               hi_write, lo_write, z_write, pc_write, mdr_write, ir_write, y_write, mar_write,
               mem_read, mem_write, outport_write, conff_write,
               hi_read, lo_read, z_lo_read, z_hi_read, pc_read, mdr_read, inport_read, c_read,
               alu_opcode, div_reset, mdr_select, inc_pc
    );

    modport slave (
        output stop, ir, bus,
        input  run, clear, gra, grb, grc, ba_read, regfile_read, regfile_write,
               hi_write, lo_write, z_write, pc_write, mdr_write, ir_write, y_write, mar_write,
               mem_read, mem_write, outport_write, conff_write,
               hi_read, lo_read, z_lo_read, z_hi_read, pc_read, mdr_read, inport_read, c_read,
               alu_opcode, div_reset, mdr_select, inc_pc
    );
endinterface

// File: rtl/src_control_sequencer_con_ff.sv
// CON FF: branch condition decoded from the bus and captured on conff_write.
module con_ff
    import src_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [1:0]  cc_i,
    input  logic [31:0] bus_i,
    output logic        con_o
);
    logic cond;
    logic con_q;

    always_comb begin
        cond = 1'b0;
        case (cc_i)
            CC_ZERO: cond = (bus_i == 32'd0);
            CC_NZ:   cond = (bus_i != 32'd0);
            CC_POS:  cond = ~bus_i[31];
            CC_NEG:  cond = bus_i[31];
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       con_q <= 1'b0;
        else if (en_i) con_q <= cond;
    end

    assign con_o = con_q;
endmodule

// File: rtl/src_control_sequencer.sv
// Hardwired Moore control unit for Mini-SRC: fetch T0-T3, opcode-driven execute steps,
// a held DIV state for the sequential divider, and an absorbing HALT.
module src_control_sequencer
    import src_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    src_control_sequencer_if.master ifc
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_t         c;
    logic          con;
    logic [4:0]    op;
    logic          is_ralu, is_imm, is_un, is_ldst, unused_ir;

    assign op        = ifc.ir[31:27];
    assign is_ralu   = (op >= OP_ADD) && (op <= OP_OR);
    assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_un     = (op == OP_NEG) || (op == OP_NOT);
    assign is_ldst   = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign unused_ir = ^{ifc.ir[26:21], ifc.ir[18:0]};

    con_ff u_con_ff (
        .clk   (clk),
        .rst   (reset),
        .en_i  (c.conff_write),
        .cc_i  (ifc.ir[20:19]),
        .bus_i (ifc.bus),
        .con_o (con)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c       = '0;
        case (state_q)
            S_RESET: begin c.clear = 1'b1; state_d = S_T0; end
            S_T0: begin
                c.pc_read = 1'b1; c.mar_write = 1'b1; c.inc_pc = 1'b1;
                state_d = ifc.stop ? S_HALT : S_T1;
            end
            S_T1: begin c.mem_read = 1'b1; state_d = S_T2; end
            S_T2: begin c.mem_read = 1'b1; c.mdr_select = 1'b1; c.mdr_write = 1'b1; state_d = S_T3; end
            S_T3: begin c.mdr_read = 1'b1; c.ir_write = 1'b1; state_d = S_T4; end
            S_T4: begin
                cnt_d   = '0;
                state_d = S_T0;
                if (is_ralu || is_imm) begin
                    c.grb = 1'b1; c.regfile_read = 1'b1; c.y_write = 1'b1; state_d = S_T5;
                end else if (is_un) begin
                    c.grb = 1'b1; c.regfile_read = 1'b1; c.z_write = 1'b1;
                    c.alu_opcode = alu_of(op); state_d = S_T5;
                end else if (is_ldst) begin
                    c.grb = 1'b1; c.ba_read = 1'b1; c.regfile_read = 1'b1; c.y_write = 1'b1;
                    state_d = S_T5;
                end else begin
                    case (op)
                        OP_MUL:  begin c.gra = 1'b1; c.regfile_read = 1'b1; c.y_write = 1'b1; state_d = S_T5; end
                        OP_DIV:  begin
                            c.gra = 1'b1; c.regfile_read = 1'b1; c.y_write = 1'b1; c.div_reset = 1'b1;
                            state_d = S_DIV;
                        end
                        OP_BR:   begin c.gra = 1'b1; c.regfile_read = 1'b1; c.conff_write = 1'b1; state_d = S_T5; end
                        OP_JR:   begin c.gra = 1'b1; c.regfile_read = 1'b1; c.pc_write = 1'b1; end
                        OP_JAL:  begin c.pc_read = 1'b1; c.grb = 1'b1; c.regfile_write = 1'b1; state_d = S_T5; end
                        OP_IN:   begin c.inport_read = 1'b1; c.gra = 1'b1; c.regfile_write = 1'b1; end
                        OP_OUT:  begin c.gra = 1'b1; c.regfile_read = 1'b1; c.outport_write = 1'b1; end
                        OP_MFHI: begin c.hi_read = 1'b1; c.gra = 1'b1; c.regfile_write = 1'b1; end
                        OP_MFLO: begin c.lo_read = 1'b1; c.gra = 1'b1; c.regfile_write = 1'b1; end
                        OP_HALT: state_d = S_HALT;
                        default: state_d = S_T0;
                    endcase
                end
            end
            S_T5: begin
                state_d = S_T6;
                if (is_ralu) begin
                    c.grc = 1'b1; c.regfile_read = 1'b1; c.z_write = 1'b1; c.alu_opcode = alu_of(op);
                end else if (is_imm) begin
                    c.c_read = 1'b1; c.z_write = 1'b1; c.alu_opcode = alu_of(op);
                end else if (is_un) begin
                    c.z_lo_read = 1'b1; c.gra = 1'b1; c.regfile_write = 1'b1; state_d = S_T0;
                end else if (is_ldst) begin
                    c.c_read = 1'b1; c.z_write = 1'b1; c.alu_opcode = ALU_ADD;
                end else if (op == OP_MUL) begin
                    c.grb = 1'b1; c.regfile_read = 1'b1; c.z_write = 1'b1; c.alu_opcode = ALU_MUL;
                end else if (op == OP_BR) begin
                    c.pc_read = 1'b1; c.y_write = 1'b1;
                end else begin
                    // jal second step; anything else cannot reach T5
                    c.gra = 1'b1; c.regfile_read = (op == OP_JAL); c.pc_write = (op == OP_JAL);
                    c.gra = (op == OP_JAL); state_d = S_T0;
                end
            end
            S_DIV: begin
                c.grb = 1'b1; c.regfile_read = 1'b1; c.alu_opcode = ALU_DIV;
                if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                    c.z_write = 1'b1; state_d = S_T6;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_T6: begin
                state_d = S_T0;
                if (is_ralu || is_imm || op == OP_LDI) begin
                    c.z_lo_read = 1'b1; c.gra = 1'b1; c.regfile_write = 1'b1;
                end else if (op == OP_MUL || op == OP_DIV) begin
                    c.z_lo_read = 1'b1; c.lo_write = 1'b1; state_d = S_T7;
                end else if (op == OP_LD || op == OP_ST) begin
                    c.z_lo_read = 1'b1; c.mar_write = 1'b1; state_d = S_T7;
                end else if (op == OP_BR) begin
                    c.c_read = 1'b1; c.z_write = 1'b1; c.alu_opcode = ALU_ADD; state_d = S_T7;
                end
            end
            S_T7: begin
                state_d = S_T0;
                if (op == OP_MUL || op == OP_DIV) begin
                    c.z_hi_read = 1'b1; c.hi_write = 1'b1;
                end else if (op == OP_LD) begin
                    c.mem_read = 1'b1; state_d = S_T8;
                end else if (op == OP_ST) begin
                    c.gra = 1'b1; c.regfile_read = 1'b1; c.mdr_write = 1'b1; state_d = S_T8;
                end else if (op == OP_BR) begin
                    c.z_lo_read = 1'b1; c.pc_write = con;
                end
            end
            S_T8: begin
                state_d = S_T0;
                if (op == OP_LD) begin
                    c.mem_read = 1'b1; c.mdr_select = 1'b1; c.mdr_write = 1'b1; state_d = S_T9;
                end else if (op == OP_ST) begin
                    c.mem_write = 1'b1;
                end
            end
            S_T9: begin c.mdr_read = 1'b1; c.gra = 1'b1; c.regfile_write = 1'b1; state_d = S_T0; end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
        c.run = (state_q != S_RESET) && (state_q != S_HALT);
    end

    assign ifc.run           = c.run;
    assign ifc.clear         = c.clear;
    assign ifc.gra           = c.gra;
    assign ifc.grb           = c.grb;
    assign ifc.grc           = c.grc;
    assign ifc.ba_read       = c.ba_read;
    assign ifc.regfile_read  = c.regfile_read;
    assign ifc.regfile_write = c.regfile_write;
    assign ifc.hi_write      = c.hi_write;
    assign ifc.lo_write      = c.lo_write;
    assign ifc.z_write       = c.z_write;
    assign ifc.pc_write      = c.pc_write;
    assign ifc.mdr_write     = c.mdr_write;
    assign ifc.ir_write      = c.ir_write;
    assign ifc.y_write       = c.y_write;
    assign ifc.mar_write     = c.mar_write;
    assign ifc.mem_read      = c.mem_read;
    assign ifc.mem_write     = c.mem_write;
    assign ifc.outport_write = c.outport_write;
    assign ifc.conff_write   = c.conff_write;
    assign ifc.hi_read       = c.hi_read;
    assign ifc.lo_read       = c.lo_read;
    assign ifc.z_lo_read     = c.z_lo_read;
    assign ifc.z_hi_read     = c.z_hi_read;
    assign ifc.pc_read       = c.pc_read;
    assign ifc.mdr_read      = c.mdr_read;
    assign ifc.inport_read   = c.inport_read;
    assign ifc.c_read        = c.c_read;
    assign ifc.alu_opcode    = c.alu_opcode;
    assign ifc.div_reset     = c.div_reset;
    assign ifc.mdr_select    = c.mdr_select;
    assign ifc.inc_pc        = c.inc_pc;
endmodule

// File: tb/tb_src_control_sequencer.sv
// Bench for src_control_sequencer: each instruction is expanded into its per-cycle strobe list
// from the instruction's RTN table and compared cycle by cycle against the DUT.
module tb_src_control_sequencer;
    logic clk = 1'b0;
    logic reset;

    src_control_sequencer_if ifc();

    src_control_sequencer #(.DIV_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
    );

    always #5 clk = ~clk;

    localparam logic [30:0] B1 = 31'd1;
    localparam logic [30:0] RUN = B1 << 30, CLR = B1 << 29, GRA = B1 << 28, GRB = B1 << 27;
    localparam logic [30:0] GRC = B1 << 26, BA = B1 << 25, RFR = B1 << 24, RFW = B1 << 23;
    localparam logic [30:0] HIW = B1 << 22, LOW = B1 << 21, ZW = B1 << 20, PCW = B1 << 19;
    localparam logic [30:0] MDRW = B1 << 18, IRW = B1 << 17, YW = B1 << 16, MARW = B1 << 15;
    localparam logic [30:0] MR = B1 << 14, MW = B1 << 13, OW = B1 << 12, CFW = B1 << 11;
    localparam logic [30:0] HIR = B1 << 10, LOR = B1 << 9, ZLR = B1 << 8, ZHR = B1 << 7;
    localparam logic [30:0] PCR = B1 << 6, MDRR = B1 << 5, INR = B1 << 4, CR = B1 << 3;
    localparam logic [30:0] DIVR = B1 << 2, MDRS = B1 << 1, INC = B1 << 0;

    logic [30:0] obs;
    assign obs = {ifc.run, ifc.clear, ifc.gra, ifc.grb, ifc.grc, ifc.ba_read, ifc.regfile_read,
                  ifc.regfile_write, ifc.hi_write, ifc.lo_write, ifc.z_write, ifc.pc_write,
                  ifc.mdr_write, ifc.ir_write, ifc.y_write, ifc.mar_write, ifc.mem_read,
                  ifc.mem_write, ifc.outport_write, ifc.conff_write, ifc.hi_read, ifc.lo_read,
                  ifc.z_lo_read, ifc.z_hi_read, ifc.pc_read, ifc.mdr_read, ifc.inport_read,
                  ifc.c_read, ifc.div_reset, ifc.mdr_select, ifc.inc_pc};

    typedef struct {
        logic [30:0] m;
        logic [3:0]  a;
    } step_t;

    step_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [30:0] em, input logic [3:0] ea);
        n_chk++;
        assert ({obs, ifc.alu_opcode} === {em, ea}) n_pass++;
        else $error("FAIL %s obs=%h alu=%0d exp=%h alu=%0d", tag, obs, ifc.alu_opcode, em, ea);
    endtask

    task automatic push(input logic [30:0] m, input logic [3:0] a);
        step_t s;
        s.m = m | RUN;
        s.a = a;
        q.push_back(s);
    endtask

    function automatic bit con_of(input logic [1:0] cc, input logic [31:0] b);
        case (cc)
            2'b00:   return b == 0;
            2'b01:   return b != 0;
            2'b10:   return b[31] == 1'b0;
            default: return b[31] == 1'b1;
        endcase
    endfunction

    // Expected per-cycle strobes for one instruction, fetch included.
    task automatic build(input int op, input bit con);
        push(PCR | MARW | INC, 0);
        push(MR, 0);
        push(MR | MDRS | MDRW, 0);
        push(MDRR | IRW, 0);
        if (op >= 3 && op <= 10) begin
            push(GRB | RFR | YW, 0);
            push(GRC | RFR | ZW, 4'(op - 3));
            push(ZLR | GRA | RFW, 0);
        end else if (op >= 11 && op <= 13) begin
            push(GRB | RFR | YW, 0);
            push(CR | ZW, op == 11 ? 4'd0 : (op == 12 ? 4'd6 : 4'd7));
            push(ZLR | GRA | RFW, 0);
        end else if (op == 16 || op == 17) begin
            push(GRB | RFR | ZW, op == 16 ? 4'd10 : 4'd11);
            push(ZLR | GRA | RFW, 0);
        end else if (op == 14 || op == 15) begin
            if (op == 14) begin
                push(GRA | RFR | YW, 0);
                push(GRB | RFR | ZW, 8);
            end else begin
                push(GRA | RFR | YW | DIVR, 0);
                for (int i = 0; i < 32; i++) push(GRB | RFR | (i == 31 ? ZW : '0), 9);
            end
            push(ZLR | LOW, 0);
            push(ZHR | HIW, 0);
        end else if (op <= 2) begin
            push(GRB | BA | RFR | YW, 0);
            push(CR | ZW, 0);
            if (op == 1) push(ZLR | GRA | RFW, 0);
            else         push(ZLR | MARW, 0);
            if (op == 0) begin
                push(MR, 0);
                push(MR | MDRS | MDRW, 0);
                push(MDRR | GRA | RFW, 0);
            end else if (op == 2) begin
                push(GRA | RFR | MDRW, 0);
                push(MW, 0);
            end
        end else begin
            case (op)
                18: begin
                    push(GRA | RFR | CFW, 0);
                    push(PCR | YW, 0);
                    push(CR | ZW, 0);
                    push(ZLR | (con ? PCW : '0), 0);
                end
                19: push(GRA | RFR | PCW, 0);
                20: begin push(PCR | GRB | RFW, 0); push(GRA | RFR | PCW, 0); end
                21: push(INR | GRA | RFW, 0);
                22: push(GRA | RFR | OW, 0);
                23: push(HIR | GRA | RFW, 0);
                24: push(LOR | GRA | RFW, 0);
                default: push('0, 0);
            endcase
        end
    endtask

    task automatic run_instr(input logic [31:0] ir_v, input logic [31:0] bus_v, input bit stop_v,
                             input string tag);
        logic [4:0] opv;
        logic [1:0] ccv;
        opv = ir_v[31:27];
        ccv = ir_v[20:19];
        q.delete();
        build(int'(opv), con_of(ccv, bus_v));
        ifc.ir  = ir_v;
        ifc.bus = bus_v;
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("%s_c%0d", tag, i), q[i].m, q[i].a);
            @(posedge clk); #1;
            if (i == 0 && stop_v) ifc.stop = 1'b1;
        end
    endtask

    task automatic halt_check(input int n);
        for (int i = 0; i < n; i++) begin
            chk("halted", '0, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_async", CLR, 0);
        @(posedge clk); #1;
        chk("rst_hold", CLR, 0);
        reset = 1'b0;
        ifc.stop = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] rb;
        reset    = 1'b1;
        ifc.stop = 1'b0;
        ifc.ir   = 32'd0;
        ifc.bus  = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("reset", CLR, 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        run_instr(32'h1891_0000, 32'd0, 0, "add");
        run_instr(32'h9000_0000, 32'd0, 0, "br_eq_taken");
        run_instr(32'h9000_0000, 32'd5, 0, "br_eq_not");
        run_instr(32'h9008_0000, 32'd5, 0, "br_nz_taken");
        run_instr(32'h9010_0000, 32'h8000_0000, 0, "br_pos_not");
        run_instr(32'h9018_0000, 32'h8000_0000, 0, "br_neg_taken");
        run_instr(32'h7800_0000, 32'd0, 0, "div");
        run_instr(32'h0080_0000, 32'd0, 0, "ld");
        run_instr(32'h1000_0000, 32'd0, 0, "st");
        run_instr(32'h0800_0000, 32'd0, 0, "ldi");
        run_instr(32'h7000_0000, 32'd0, 0, "mul");
        run_instr(32'hF800_0000, 32'd0, 0, "op31");

        for (int n = 0; n < 40; n++) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'd26) rop = 5'd25;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_instr({rop, 27'($urandom)}, rb, 0, $sformatf("rnd%0d_op%0d", n, rop));
        end

        run_instr(32'h1891_0000, 32'd0, 1, "stop_add");
        chk("stop_t0", RUN | PCR | MARW | INC, 0);
        @(posedge clk); #1;
        halt_check(3);
        do_reset();

        run_instr(32'hD000_0000, 32'd0, 0, "halt_op");
        halt_check(2);
        do_reset();

        ifc.ir = 32'h7800_0000;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        do_reset();
        run_instr(32'h2000_0000, 32'd0, 0, "sub_after_abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
